// File: rtl/decode_queue_if.sv
// Fetch-to-execute bus of decode_queue: fetch handshake in, decoded head entry out.
// The queue side uses the slave modport; the fetch/execute side uses master.
interface decode_queue_if #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_inst;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_inst;
  logic [PC_WIDTH-1:0] out_pc;
  logic [26:0]         out_ctrl;
  logic [CW-1:0]       count;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_ctrl, count
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_ctrl, count
  );
endinterface

// File: rtl/decode_queue.sv
// Buffered MIPS decoder: decodes on push, holds DEPTH entries in order, flushable.
// Define DECODE_QUEUE_MULDIV_EN to decode mult/multu/div/divu/mfhi/mflo.
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  decode_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [PW-1:0] LASTIDX = PW'(DEPTH - 1);

  localparam logic [1:0] ARITH = 2'b00, LOGIC = 2'b01, SHIFT = 2'b10, COMPARE = 2'b11;

  // Two reserved zero bits sit above write_reg so the bundle is 27 bits wide.
  typedef struct packed {
    logic [1:0] rsvd;
    logic       writeReg;
    logic       memOrAlu;
    logic       writeMem;
    logic       readMem;
    logic [1:0] memSize;
    logic       memSigned;
    logic [1:0] aluType;
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic       aluSrcB;
    logic [1:0] regDes;
    logic       immSigned;
    logic       immLui;
    logic [1:0] branch;
    logic [1:0] jump;
    logic [2:0] hilo;
    logic       illegal;
  } CtrlBundle;

  typedef struct packed {
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] pc;
    CtrlBundle           ctrl;
  } QueueEntry;

  function automatic CtrlBundle decodeInst(input logic [5:0] opcode, input logic [5:0] funct,
                                           input logic [4:0] rt, input logic [4:0] rd);
    CtrlBundle  c;
    logic [4:0] destIdx;
    c = '0;
    if (opcode == 6'h00) begin
      c.regDes   = 2'b01;
      c.writeReg = 1'b1;
      case (funct)
        6'h00: begin c.aluType = SHIFT; c.aluOp = 2'b00; c.aluSrcA = 1'b1; end
        6'h02: begin c.aluType = SHIFT; c.aluOp = 2'b01; c.aluSrcA = 1'b1; end
        6'h03: begin c.aluType = SHIFT; c.aluOp = 2'b10; c.aluSrcA = 1'b1; end
        6'h04: begin c.aluType = SHIFT; c.aluOp = 2'b00; end
        6'h06: begin c.aluType = SHIFT; c.aluOp = 2'b01; end
        6'h07: begin c.aluType = SHIFT; c.aluOp = 2'b10; end
        6'h08: begin c.jump = 2'b10; c.writeReg = 1'b0; end
`ifdef DECODE_QUEUE_MULDIV_EN
        6'h10: c.hilo = 3'b101;
        6'h12: c.hilo = 3'b110;
        6'h18: begin c.hilo = 3'b001; c.writeReg = 1'b0; end
        6'h19: begin c.hilo = 3'b010; c.writeReg = 1'b0; end
        6'h1A: begin c.hilo = 3'b011; c.writeReg = 1'b0; end
        6'h1B: begin c.hilo = 3'b100; c.writeReg = 1'b0; end
`endif
        6'h20, 6'h21: begin c.aluType = ARITH;   c.aluOp = 2'b00; end
        6'h22, 6'h23: begin c.aluType = ARITH;   c.aluOp = 2'b01; end
        6'h24:        begin c.aluType = LOGIC;   c.aluOp = 2'b00; end
        6'h25:        begin c.aluType = LOGIC;   c.aluOp = 2'b01; end
        6'h26:        begin c.aluType = LOGIC;   c.aluOp = 2'b10; end
        6'h27:        begin c.aluType = LOGIC;   c.aluOp = 2'b11; end
        6'h2A:        begin c.aluType = COMPARE; c.aluOp = 2'b00; end
        6'h2B:        begin c.aluType = COMPARE; c.aluOp = 2'b01; end
        default:      c.illegal = 1'b1;
      endcase
    end else begin
      c.writeReg = 1'b1;
      c.aluSrcB  = 1'b1;
      case (opcode)
        6'h03: begin c.aluSrcB = 1'b0; c.regDes = 2'b10; c.jump = 2'b01; end
        6'h04, 6'h05: begin
          c.aluSrcB  = 1'b0;
          c.writeReg = 1'b0;
          c.aluType  = ARITH;
          c.aluOp    = 2'b01;
          c.branch   = (opcode == 6'h04) ? 2'b01 : 2'b10;
        end
        6'h08, 6'h09: c.immSigned = 1'b1;
        6'h0A: begin c.aluType = COMPARE; c.immSigned = 1'b1; end
        6'h0C: begin c.aluType = LOGIC; c.aluOp = 2'b00; end
        6'h0D: begin c.aluType = LOGIC; c.aluOp = 2'b01; end
        6'h0E: begin c.aluType = LOGIC; c.aluOp = 2'b10; end
        6'h0F: begin c.aluType = LOGIC; c.aluOp = 2'b01; c.immLui = 1'b1; end
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
          c.readMem   = 1'b1;
          c.memOrAlu  = 1'b1;
          c.immSigned = 1'b1;
          c.memSize   = (opcode[1:0] == 2'b11) ? 2'b10 : {1'b0, opcode[0]};
          c.memSigned = (opcode == 6'h20) || (opcode == 6'h21);
        end
        6'h28, 6'h29, 6'h2B: begin
          c.writeMem  = 1'b1;
          c.writeReg  = 1'b0;
          c.immSigned = 1'b1;
          c.memSize   = (opcode[1:0] == 2'b11) ? 2'b10 : {1'b0, opcode[0]};
        end
        default: c.illegal = 1'b1;
      endcase
    end

    if (c.illegal) begin
      c         = '0;
      c.illegal = 1'b1;
    end else begin
      case (c.regDes)
        2'b00:   destIdx = rt;
        2'b01:   destIdx = rd;
        default: destIdx = 5'd31;
      endcase
      if (destIdx == 5'd0) c.writeReg = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
    return (ptr == LASTIDX) ? '0 : ptr + PW'(1);
  endfunction

  logic [CW-1:0] countQ;
  logic [PW-1:0] wrPtr, rdPtr;
  logic          doPush, doPop;
  QueueEntry     newEntry, headEntry;
  QueueEntry     storage [DEPTH];

  assign bus.in_ready  = (countQ < FULL);
  assign bus.out_valid = (countQ != '0);
  assign doPush = bus.in_valid  && bus.in_ready  && !bus.flush;
  assign doPop  = bus.out_valid && bus.out_ready && !bus.flush;

  assign newEntry.inst = bus.in_inst;
  assign newEntry.pc   = bus.in_pc;
  assign newEntry.ctrl = decodeInst(bus.in_inst[31:26], bus.in_inst[5:0],
                                    bus.in_inst[20:16], bus.in_inst[15:11]);

  // NOTE: storage has no reset; every read path is gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (doPush) storage[wrPtr] <= newEntry;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      countQ <= '0;
      wrPtr  <= '0;
      rdPtr  <= '0;
    end else begin
      if (doPush) wrPtr <= advance(wrPtr);
      if (doPop)  rdPtr <= advance(rdPtr);
      if (doPush && !doPop)      countQ <= countQ + CW'(1);
      else if (doPop && !doPush) countQ <= countQ - CW'(1);
    end
  end

  assign headEntry    = storage[rdPtr];
  assign bus.out_inst = bus.out_valid ? headEntry.inst : '0;
  assign bus.out_pc   = bus.out_valid ? headEntry.pc   : '0;
  assign bus.out_ctrl = bus.out_valid ? headEntry.ctrl : '0;
  assign bus.count    = countQ;
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed steps plus random traffic against
// a queue-based reference model with a mnemonic-level decoder.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int PCW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failures = 0;

  decode_queue_if #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) bus ();
  decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]    inst;
    logic [PCW-1:0] pc;
    logic [26:0]    ctrl;
  } ModelEntry;

  ModelEntry model[$];

  logic [5:0] rFuncts[$] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h10, 6'h12,
                             6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                             6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F};
  logic [5:0] iOps[$] = '{6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                          6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h3E};

  // Reference decoder: one line per mnemonic, fields packed MSB-first below two reserved bits.
  function automatic logic [26:0] refCtrl(input logic [31:0] inst);
    logic       wr, moa, wm, rm, msg, sa, sb, is, il, ill, muldiv;
    logic [1:0] ms, at, ao, rd, br, jp;
    logic [2:0] hl;
    logic [4:0] dest;
    logic [5:0] op, fn;
    {wr, moa, wm, rm, msg, sa, sb, is, il, ill} = '0;
    {ms, at, ao, rd, br, jp, hl} = '0;
`ifdef DECODE_QUEUE_MULDIV_EN
    muldiv = 1'b1;
`else
    muldiv = 1'b0;
`endif
    op = inst[31:26];
    fn = inst[5:0];
    if (op == 6'h00) begin
      rd = 2'b01; wr = 1'b1; dest = inst[15:11];
      case (fn)
        6'h00: begin at = 2; ao = 0; sa = 1; end            // sll
        6'h02: begin at = 2; ao = 1; sa = 1; end            // srl
        6'h03: begin at = 2; ao = 2; sa = 1; end            // sra
        6'h04: begin at = 2; ao = 0; end                    // sllv
        6'h06: begin at = 2; ao = 1; end                    // srlv
        6'h07: begin at = 2; ao = 2; end                    // srav
        6'h08: begin jp = 2; wr = 0; end                    // jr
        6'h10: if (muldiv) hl = 5; else ill = 1;            // mfhi
        6'h12: if (muldiv) hl = 6; else ill = 1;            // mflo
        6'h18: if (muldiv) begin hl = 1; wr = 0; end else ill = 1;
        6'h19: if (muldiv) begin hl = 2; wr = 0; end else ill = 1;
        6'h1A: if (muldiv) begin hl = 3; wr = 0; end else ill = 1;
        6'h1B: if (muldiv) begin hl = 4; wr = 0; end else ill = 1;
        6'h20, 6'h21: begin at = 0; ao = 0; end             // add, addu
        6'h22, 6'h23: begin at = 0; ao = 1; end             // sub, subu
        6'h24: begin at = 1; ao = 0; end                    // and
        6'h25: begin at = 1; ao = 1; end                    // or
        6'h26: begin at = 1; ao = 2; end                    // xor
        6'h27: begin at = 1; ao = 3; end                    // nor
        6'h2A: begin at = 3; ao = 0; end                    // slt
        6'h2B: begin at = 3; ao = 1; end                    // sltu
        default: ill = 1;
      endcase
    end else begin
      rd = 2'b00; sb = 1; wr = 1; dest = inst[20:16];
      case (op)
        6'h03: begin sb = 0; rd = 2; jp = 1; dest = 5'd31; end      // jal
        6'h04: begin sb = 0; wr = 0; at = 0; ao = 1; br = 1; end    // beq
        6'h05: begin sb = 0; wr = 0; at = 0; ao = 1; br = 2; end    // bne
        6'h08, 6'h09: is = 1;                                       // addi, addiu
        6'h0A: begin at = 3; is = 1; end                            // slti
        6'h0C: begin at = 1; ao = 0; end                            // andi
        6'h0D: begin at = 1; ao = 1; end                            // ori
        6'h0E: begin at = 1; ao = 2; end                            // xori
        6'h0F: begin at = 1; ao = 1; il = 1; end                    // lui
        6'h20: begin rm = 1; moa = 1; is = 1; ms = 0; msg = 1; end  // lb
        6'h21: begin rm = 1; moa = 1; is = 1; ms = 1; msg = 1; end  // lh
        6'h23: begin rm = 1; moa = 1; is = 1; ms = 2; end           // lw
        6'h24: begin rm = 1; moa = 1; is = 1; ms = 0; end           // lbu
        6'h25: begin rm = 1; moa = 1; is = 1; ms = 1; end           // lhu
        6'h28: begin wm = 1; wr = 0; is = 1; ms = 0; end            // sb
        6'h29: begin wm = 1; wr = 0; is = 1; ms = 1; end            // sh
        6'h2B: begin wm = 1; wr = 0; is = 1; ms = 2; end            // sw
        default: ill = 1;
      endcase
    end
    if (ill) return 27'd1;
    if (dest == 5'd0) wr = 1'b0;
    return {2'b00, wr, moa, wm, rm, ms, msg, at, ao, sa, sb, rd, is, il, br, jp, hl, 1'b0};
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 3) == 0) w[15:11] = 5'd0;
    if ($urandom_range(0, 3) == 0) w[20:16] = 5'd0;
    if ($urandom_range(0, 1) == 0) begin
      w[31:26] = 6'h00;
      w[5:0]   = rFuncts[$urandom_range(0, rFuncts.size() - 1)];
    end else begin
      w[31:26] = iOps[$urandom_range(0, iOps.size() - 1)];
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, "_count"}, 64'(bus.count), 64'(model.size()));
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(model.size() != 0));
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(model.size() < DEPTH));
    if (model.size() != 0) begin
      check({tag, "_out_inst"}, 64'(bus.out_inst), 64'(model[0].inst));
      check({tag, "_out_pc"}, 64'(bus.out_pc), 64'(model[0].pc));
      check({tag, "_out_ctrl"}, 64'(bus.out_ctrl), 64'(model[0].ctrl));
    end else begin
      check({tag, "_out_inst0"}, 64'(bus.out_inst), 64'd0);
      check({tag, "_out_pc0"}, 64'(bus.out_pc), 64'd0);
      check({tag, "_out_ctrl0"}, 64'(bus.out_ctrl), 64'd0);
    end
  endtask

  // One clock: the model applies the rules to the inputs held across the edge.
  task automatic cycle(input string tag);
    bit push, pop;
    ModelEntry e;
    @(posedge clk);
    if (rst || bus.flush) begin
      model.delete();
    end else begin
      push = bus.in_valid && (model.size() < DEPTH);
      pop  = bus.out_ready && (model.size() != 0);
      e.inst = bus.in_inst;
      e.pc   = bus.in_pc;
      e.ctrl = refCtrl(bus.in_inst);
      if (pop)  void'(model.pop_front());
      if (push) model.push_back(e);
    end
    #1;
    checkAll(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = $urandom() & 32'hFFFF_FFFC;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  initial begin
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle("rst");
    cycle("rst");
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    cycle("idle");

    // sll $2,$2,10
    drive(1'b1, 32'h0002_1280, 1'b0, 1'b0);
    cycle("sll");
    check("sll_write_reg", 64'(bus.out_ctrl[24]), 64'd1);
    check("sll_alu_type", 64'(bus.out_ctrl[17:16]), 64'd2);
    check("sll_alu_op", 64'(bus.out_ctrl[15:14]), 64'd0);
    check("sll_src_a", 64'(bus.out_ctrl[13]), 64'd1);
    check("sll_reg_des", 64'(bus.out_ctrl[11:10]), 64'd1);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    cycle("sll_pop");

    // Fill past full, then drain across the pointer wrap.
    for (int i = 0; i <= DEPTH; i++) begin
      drive(1'b1, randInst(), 1'b0, 1'b0);
      cycle("fill");
    end
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_count", 64'(bus.count), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      cycle("drain");
    end

    // Streaming: one push and one pop per cycle keeps occupancy at 1.
    drive(1'b1, randInst(), 1'b0, 1'b0);
    cycle("stream_prime");
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, randInst(), 1'b1, 1'b0);
      cycle("stream");
      check("stream_count", 64'(bus.count), 64'd1);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    cycle("stream_end");

    // lw $3,4($2) followed by nop
    drive(1'b1, 32'h8C43_0004, 1'b0, 1'b0);
    cycle("lw");
    drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    cycle("nop");
    check("lw_read_mem", 64'(bus.out_ctrl[21]), 64'd1);
    check("lw_mem_size", 64'(bus.out_ctrl[20:19]), 64'd2);
    check("lw_imm_signed", 64'(bus.out_ctrl[9]), 64'd1);
    check("lw_reg_des", 64'(bus.out_ctrl[11:10]), 64'd0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    cycle("lw_pop");
    check("nop_write_reg", 64'(bus.out_ctrl[24]), 64'd0);
    check("nop_alu_type", 64'(bus.out_ctrl[17:16]), 64'd2);
    cycle("nop_pop");

    // Flush at count 3 with a same-cycle push and pop request.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, randInst(), 1'b0, 1'b0);
      cycle("pre_flush");
    end
    drive(1'b1, randInst(), 1'b1, 1'b1);
    cycle("flush");
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_out_ctrl", 64'(bus.out_ctrl), 64'd0);

    // mult $2,$3
    drive(1'b1, 32'h0043_0018, 1'b0, 1'b0);
    cycle("mult");
`ifdef DECODE_QUEUE_MULDIV_EN
    check("mult_hilo", 64'(bus.out_ctrl[3:1]), 64'd1);
    check("mult_illegal", 64'(bus.out_ctrl[0]), 64'd0);
`else
    check("mult_hilo", 64'(bus.out_ctrl[3:1]), 64'd0);
    check("mult_illegal", 64'(bus.out_ctrl[0]), 64'd1);
`endif
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    cycle("mult_pop");

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), randInst(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0);
      cycle("rand");
    end

    // Reset mid-stream, with a flush and push requested in the same cycle.
    drive(1'b1, randInst(), 1'b0, 1'b0);
    cycle("pre_rst");
    drive(1'b1, randInst(), 1'b1, 1'b1);
    rst = 1'b1;
    cycle("mid_rst");
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    cycle("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
